// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with fixed request-to-response latency
// One request in flight at a time; req_ready low while the access is waiting out its latency.
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                w_accept;
  logic                w_enter_resp;
  logic                w_op_write;
  logic [ADDR_W-1:0]   w_op_addr;
  logic [DATA_W-1:0]   w_op_wdata;
  logic                w_op_in_range;
  logic [IDX_W-1:0]    w_op_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        req_ready  = 1'b1;
        resp_valid = (r_state == S_RESP);
        w_accept   = req_valid;
        if (req_valid) begin
          if (LATENCY == 1) begin
            w_state_nxt  = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt  = S_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // With single-cycle latency the array is touched on the accept edge itself,
  // so the live request fields are used instead of the latched copies.
  assign w_op_write    = (LATENCY == 1) ? req_write : r_write;
  assign w_op_addr     = (LATENCY == 1) ? req_addr  : r_addr;
  assign w_op_wdata    = (LATENCY == 1) ? req_wdata : r_wdata;
  assign w_op_in_range = ({1'b0, w_op_addr} < DEPTH_LIM);
  assign w_op_idx      = w_op_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_op_write && w_op_in_range) begin
      r_mem[w_op_idx] <= w_op_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_err <= !w_op_in_range;
      if (!w_op_in_range) begin
        r_rdata <= '0;
      end else if (w_op_write) begin
        r_rdata <= w_op_wdata;
      end else begin
        r_rdata <= r_mem[w_op_idx];
      end
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder
// Three instances: default (LATENCY=2, DEPTH=256), DEPTH=128, LATENCY=1.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic [2:0]  vld;
  logic        wr;
  logic [7:0]  addr;
  logic [31:0] wdata;
  wire  [2:0]  rdy;
  wire  [2:0]  rv;
  wire  [2:0]  er;
  wire  [31:0] rd [3];

  int n_chk;
  int n_err;

  logic [31:0] r_data;
  logic        r_e;

  dmem_responder u_a (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]), .req_write(wr),
    .req_addr(addr), .req_wdata(wdata), .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(er[0])
  );

  dmem_responder #(.DEPTH(128)) u_b (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]), .req_write(wr),
    .req_addr(addr), .req_wdata(wdata), .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(er[1])
  );

  dmem_responder #(.LATENCY(1)) u_c (
    .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy[2]), .req_write(wr),
    .req_addr(addr), .req_wdata(wdata), .resp_valid(rv[2]), .resp_rdata(rd[2]), .resp_err(er[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on instance k and wait (bounded) for its response.
  task automatic do_req(input int k, input logic w, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] r, output logic e);
    int n;
    wr = w; addr = a; wdata = d; vld[k] = 1'b1;
    n = 0;
    while (!rdy[k] && n < 10) begin tick(); n++; end
    tick();
    vld[k] = 1'b0;
    n = 0;
    while (!rv[k] && n < 10) begin tick(); n++; end
    if (!rv[k]) check("resp_timeout", 32'd0, 32'd1);
    r = rd[k];
    e = er[k];
    tick();
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b1; vld = 3'b000; wr = 1'b0; addr = 8'h00; wdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", {31'd0, rdy[0]}, 32'd1);
    check("rst_rvalid", {31'd0, rv[0]}, 32'd0);
    check("rst_rdata", rd[0], 32'h0);
    check("rst_err", {31'd0, er[0]}, 32'd0);

    // 1: store then load at 0x10, LATENCY=2
    vld[0] = 1'b1; wr = 1'b1; addr = 8'h10; wdata = 32'hDEADBEEF;
    tick();
    vld[0] = 1'b0;
    check("t1_st_wait_rv", {31'd0, rv[0]}, 32'd0);
    check("t1_st_wait_rdy", {31'd0, rdy[0]}, 32'd0);
    tick();
    check("t1_st_rv", {31'd0, rv[0]}, 32'd1);
    check("t1_st_rdata", rd[0], 32'hDEADBEEF);
    check("t1_st_err", {31'd0, er[0]}, 32'd0);
    vld[0] = 1'b1; wr = 1'b0; addr = 8'h10; wdata = 32'h0;
    tick();
    vld[0] = 1'b0;
    check("t1_ld_wait_rv", {31'd0, rv[0]}, 32'd0);
    check("t1_ld_wait_rdy", {31'd0, rdy[0]}, 32'd0);
    tick();
    check("t1_ld_rv", {31'd0, rv[0]}, 32'd1);
    check("t1_ld_rdata", rd[0], 32'hDEADBEEF);
    tick();
    check("t1_idle_rv", {31'd0, rv[0]}, 32'd0);

    // 2: back-to-back loads with req_valid held high
    do_req(0, 1'b1, 8'h01, 32'h11, r_data, r_e);
    do_req(0, 1'b1, 8'h02, 32'h22, r_data, r_e);
    vld[0] = 1'b1; wr = 1'b0; addr = 8'h01;
    check("t2_rdy_T", {31'd0, rdy[0]}, 32'd1);
    tick();
    addr = 8'h02;
    check("t2_rdy_T1", {31'd0, rdy[0]}, 32'd0);
    check("t2_rv_T1", {31'd0, rv[0]}, 32'd0);
    tick();
    check("t2_rv_T2", {31'd0, rv[0]}, 32'd1);
    check("t2_rdata_T2", rd[0], 32'h11);
    check("t2_rdy_T2", {31'd0, rdy[0]}, 32'd1);
    tick();
    vld[0] = 1'b0;
    check("t2_rdy_T3", {31'd0, rdy[0]}, 32'd0);
    check("t2_rv_T3", {31'd0, rv[0]}, 32'd0);
    tick();
    check("t2_rv_T4", {31'd0, rv[0]}, 32'd1);
    check("t2_rdata_T4", rd[0], 32'h22);
    tick();

    // 3: request during WAIT is ignored
    do_req(0, 1'b1, 8'h04, 32'h44, r_data, r_e);
    do_req(0, 1'b1, 8'h05, 32'h55, r_data, r_e);
    vld[0] = 1'b1; wr = 1'b0; addr = 8'h04;
    tick();
    wr = 1'b1; addr = 8'h05; wdata = 32'h00000BAD;
    check("t3_rdy_wait", {31'd0, rdy[0]}, 32'd0);
    tick();
    vld[0] = 1'b0;
    check("t3_rv", {31'd0, rv[0]}, 32'd1);
    check("t3_rdata", rd[0], 32'h44);
    tick();
    check("t3_no_extra_1", {31'd0, rv[0]}, 32'd0);
    tick();
    check("t3_no_extra_2", {31'd0, rv[0]}, 32'd0);
    do_req(0, 1'b0, 8'h05, 32'h0, r_data, r_e);
    check("t3_mem5", r_data, 32'h55);

    // 4: DEPTH=128 out-of-range access, no aliasing onto word 0
    do_req(1, 1'b1, 8'h00, 32'hCAFEF00D, r_data, r_e);
    do_req(1, 1'b1, 8'h80, 32'hFFFFFFFF, r_data, r_e);
    check("t4_st_err", {31'd0, r_e}, 32'd1);
    check("t4_st_rdata", r_data, 32'h0);
    do_req(1, 1'b0, 8'h80, 32'h0, r_data, r_e);
    check("t4_ld_err", {31'd0, r_e}, 32'd1);
    check("t4_ld_rdata", r_data, 32'h0);
    do_req(1, 1'b0, 8'h00, 32'h0, r_data, r_e);
    check("t4_mem0", r_data, 32'hCAFEF00D);
    check("t4_mem0_err", {31'd0, r_e}, 32'd0);

    // 5: reset during WAIT aborts the pending store
    do_req(0, 1'b1, 8'h20, 32'hA5A5A5A5, r_data, r_e);
    vld[0] = 1'b1; wr = 1'b1; addr = 8'h20; wdata = 32'h12345678;
    tick();
    vld[0] = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rv", {31'd0, rv[0]}, 32'd0);
    check("t5_rdy", {31'd0, rdy[0]}, 32'd1);
    tick();
    check("t5_rv_after", {31'd0, rv[0]}, 32'd0);
    do_req(0, 1'b0, 8'h20, 32'h0, r_data, r_e);
    check("t5_mem20", r_data, 32'hA5A5A5A5);

    // 6: LATENCY=1 store then load back-to-back
    vld[2] = 1'b1; wr = 1'b1; addr = 8'h30; wdata = 32'h0BADF00D;
    check("t6_rdy", {31'd0, rdy[2]}, 32'd1);
    tick();
    check("t6_st_rv", {31'd0, rv[2]}, 32'd1);
    check("t6_st_rdata", rd[2], 32'h0BADF00D);
    wr = 1'b0; wdata = 32'h0;
    tick();
    vld[2] = 1'b0;
    check("t6_ld_rv", {31'd0, rv[2]}, 32'd1);
    check("t6_ld_rdata", rd[2], 32'h0BADF00D);
    check("t6_ld_err", {31'd0, er[2]}, 32'd0);
    tick();
    check("t6_idle_rv", {31'd0, rv[2]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
